cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
- Sequencer for the 4-way set-associative cache: accepts one read/write request at a time and drives the cache strobes c0..c7 in the correct order.
- Waits out the cache's tag-compare pipeline, detects hit/miss, requests a line from memory on a miss, selects the victim way via the LRU handshake, fills it, and re-looks up the line.
- Sits between the CPU-side requester and the cache; owns the memory-fetch handshake.

Parameters:
- LOOKUP_LAT, 3, cycles from the c0 strobe until the cache's hit/and values are valid (address reg, compare, AND, OR).
- MEM_TIMEOUT, 255, max MEM_WAIT cycles before abort with error; 8-bit counter.
- CNT_W, 16, width of statistics counters (optional feature).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_we  in  1  1=write, 0=read
- req_addr  in  32  request address
- req_ready  out  1  high only in IDLE; request accepted when req_valid&req_ready
- addr_out  out  32  registered address driven to cache address input
- c0..c7  out  1 each  cache control strobes
- hit_or_miss  in  1  cache hit flag (registered in cache)
- space_in_lru  in  1  cache: 1 = no invalid/empty way, LRU eviction needed
- mem_valid  in  1  memory line present on cache data input
- resp_valid  out  1  one-cycle completion pulse
- resp_hit  out  1  first-pass lookup result, valid with resp_valid
- resp_err  out  1  memory timeout, valid with resp_valid

Behaviour:
- Async reset: state=IDLE, all c0..c7=0, resp_*=0, addr_out=0, counters=0. Reset asserted mid-operation aborts immediately; no response is issued.
- All strobes are Moore outputs decoded from state; each is high for exactly one cycle per visit unless noted.
- IDLE: req_ready=1. On accept, latch req_addr into addr_out and req_we into we_q, then go to ADDR.
- ADDR: c0=1, then go to LOOKUP with wait counter = LOOKUP_LAT-1.
- LOOKUP: count down to 0, then go to CHECK.
- CHECK: c1=1 if read, c2=1 if write. Go to EVAL.
- EVAL: sample hit_or_miss. On first pass, store it into hit_q.
  - hit: go to HIT_UPD.
  - miss on first pass: go to MISS_REQ.
  - miss on second pass: set resp_err and go to DONE; this is a fill failure.
- HIT_UPD: c3=1, with c1=1 also for reads (drives the cache output bus). Go to DONE.
- MISS_REQ: c4=1, clear timeout counter, go to MEM_WAIT.
- MEM_WAIT: wait for mem_valid.
  - mem_valid=1: go to VICTIM.
  - Counter reaches MEM_TIMEOUT: set resp_err and go to DONE.
  - mem_valid=1 on the timeout cycle: mem_valid wins.
- VICTIM: c5=1, go to VSAMP.
- VSAMP: sample space_in_lru.
  - 0: go to FILL (empty way already selected).
  - 1: go to VLRU.
- VLRU: c7=1 (select LRU way), go to FILL.
- FILL: c6=1. Set second-pass flag, reload wait counter, go to LOOKUP (re-lookup through ADDR is not needed; the address is still latched).
- DONE: resp_valid=1 for one cycle, resp_hit=hit_q, resp_err as set. Go to IDLE; clear the flags.
- A request arriving in DONE is not accepted until the next cycle (req_ready=0). Minimum accept-to-accept spacing is LOOKUP_LAT+5 cycles on a hit.
- c3 is never asserted in the same cycle as c5/c6/c7.
- A miss completes with resp_hit=0 after the second-pass hit.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses, stat_timeouts (each CNT_W bits), incremented in DONE.
  - Counters saturate at all-ones, do not wrap.
  - Reset to 0 on rst.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_ctrl_pkg holds the state enum typedef and the constants LOOKUP_LAT_DEF, MEM_TIMEOUT_DEF, and strobe index names C_ADDR=0 .. C_VLRU=7.
- One natural sub-module, cache_ctrl_stats: the saturating counters, instantiated only under CACHE_CTRL_STATS_EN.

Test Plan:
- Read 0x0000_2040 after reset, mem_valid 4 cycles after c4 -> sequence c0,c1,c4,c5,c6,c1+c3 in order; resp_valid with resp_hit=0, resp_err=0.
- Repeat read 0x0000_2040 -> no c4..c7 strobes; c1+c3 asserted LOOKUP_LAT+3 cycles after accept; resp_hit=1.
- Five misses to the same index (0x0000_0040 + n*0x2000), with space_in_lru forced 1 on the fifth -> c7 pulses exactly once, only on the fifth request.
- mem_valid held low -> resp_err=1, resp_valid exactly MEM_TIMEOUT+1 cycles after c4; a second-pass miss also yields resp_err=1.
- rst pulsed during MEM_WAIT -> all strobes 0 within the same cycle, req_ready=1 after release, no resp_valid.
- With CACHE_CTRL_STATS_EN and CNT_W=2 -> five hits leave stat_hits=3 (saturated).

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state encoding, defaults and strobe indices for the cache sequencer
package cache_ctrl_pkg;

  localparam int LOOKUP_LAT_DEF  = 3;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 16;
  localparam int WAIT_W          = 8;

  localparam int C_ADDR = 0;
  localparam int C_RD   = 1;
  localparam int C_WR   = 2;
  localparam int C_HIT  = 3;
  localparam int C_MREQ = 4;
  localparam int C_VICT = 5;
  localparam int C_FILL = 6;
  localparam int C_VLRU = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_LOOKUP,
    S_CHECK,
    S_EVAL,
    S_HIT_UPD,
    S_MISS_REQ,
    S_MEM_WAIT,
    S_VICTIM,
    S_VSAMP,
    S_VLRU,
    S_FILL,
    S_DONE
  } state_t;

endpackage

// File: rtl/cache_ctrl_stats.sv
// rtl/cache_ctrl_stats.sv - saturating hit / first-pass miss / timeout counters, bumped once per response
module cache_ctrl_stats
  import cache_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_valid,
  input  logic             evt_hit,
  input  logic             evt_err,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses,
  output logic [CNT_W-1:0] stat_timeouts
);

  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] misses_q, misses_d;
  logic [CNT_W-1:0] touts_q, touts_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // misses counts first-pass misses, so a timed-out fetch also lands here
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    touts_d  = touts_q;
    if (evt_valid) begin
      if (evt_hit) begin
        hits_d = sat_inc(hits_q);
      end else begin
        misses_d = sat_inc(misses_q);
      end
      if (evt_err) begin
        touts_d = sat_inc(touts_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      touts_q  <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      touts_q  <= touts_d;
    end
  end

  assign stat_hits     = hits_q;
  assign stat_misses   = misses_q;
  assign stat_timeouts = touts_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// rtl/cache_ctrl_fsm.sv - one-request-at-a-time sequencer driving cache strobes c0..c7 and the line fetch
// Defining CACHE_CTRL_STATS_EN adds the stat_hits / stat_misses / stat_timeouts outputs.
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
`ifdef CACHE_CTRL_STATS_EN
  parameter int CNT_W       = CNT_W_DEF,
`endif
  parameter int LOOKUP_LAT  = LOOKUP_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic [31:0] addr_out,
  output logic        c0,
  output logic        c1,
  output logic        c2,
  output logic        c3,
  output logic        c4,
  output logic        c5,
  output logic        c6,
  output logic        c7,
  input  logic        hit_or_miss,
  input  logic        space_in_lru,
  input  logic        mem_valid,
  output logic        resp_valid,
  output logic        resp_hit,
  output logic        resp_err
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_misses,
  output logic [CNT_W-1:0] stat_timeouts
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_INIT   = WAIT_W'(LOOKUP_LAT - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic              pass2_q, pass2_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic [7:0]        c_vec;

  assign wait_inc = wait_q + WAIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // LOOKUP leaves on the cycle the count would hit zero, so ADDR plus LOOKUP
  // span LOOKUP_LAT cycles and CHECK lines up with valid hit/and values
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid) state_d = S_ADDR;
      S_ADDR:     state_d = S_LOOKUP;
      S_LOOKUP:   if (wait_q <= WAIT_W'(1)) state_d = S_CHECK;
      S_CHECK:    state_d = S_EVAL;
      S_EVAL: begin
        if (hit_or_miss) begin
          state_d = S_HIT_UPD;
        end else if (pass2_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_HIT_UPD:  state_d = S_DONE;
      S_MISS_REQ: state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (mem_valid) begin
          state_d = S_VICTIM;
        end else if (wait_inc == TIMEOUT_CNT) begin
          state_d = S_DONE;
        end
      end
      S_VICTIM:   state_d = S_VSAMP;
      S_VSAMP:    state_d = space_in_lru ? S_VLRU : S_FILL;
      S_VLRU:     state_d = S_FILL;
      S_FILL:     state_d = S_LOOKUP;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    hit_d   = hit_q;
    err_d   = err_q;
    pass2_d = pass2_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          we_d   = req_we;
        end
      end
      S_ADDR: wait_d = WAIT_INIT;
      S_LOOKUP: begin
        if (wait_q != '0) wait_d = wait_q - WAIT_W'(1);
      end
      S_EVAL: begin
        if (!pass2_q) hit_d = hit_or_miss;
        if (pass2_q && !hit_or_miss) err_d = 1'b1;
      end
      S_MISS_REQ: wait_d = '0;
      S_MEM_WAIT: begin
        wait_d = wait_inc;
        if (!mem_valid && wait_inc == TIMEOUT_CNT) err_d = 1'b1;
      end
      S_FILL: begin
        pass2_d = 1'b1;
        wait_d  = WAIT_INIT;
      end
      S_DONE: begin
        hit_d   = 1'b0;
        err_d   = 1'b0;
        pass2_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      pass2_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      pass2_q <= pass2_d;
      wait_q  <= wait_d;
    end
  end

  // c1 stays up through HIT_UPD on reads so the cache drives its output bus
  always_comb begin
    c_vec      = '0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE:     req_ready = 1'b1;
      S_ADDR:     c_vec[C_ADDR] = 1'b1;
      S_CHECK: begin
        if (we_q) begin
          c_vec[C_WR] = 1'b1;
        end else begin
          c_vec[C_RD] = 1'b1;
        end
      end
      S_HIT_UPD: begin
        c_vec[C_HIT] = 1'b1;
        c_vec[C_RD]  = !we_q;
      end
      S_MISS_REQ: c_vec[C_MREQ] = 1'b1;
      S_VICTIM:   c_vec[C_VICT] = 1'b1;
      S_VLRU:     c_vec[C_VLRU] = 1'b1;
      S_FILL:     c_vec[C_FILL] = 1'b1;
      S_DONE:     resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign c0       = c_vec[C_ADDR];
  assign c1       = c_vec[C_RD];
  assign c2       = c_vec[C_WR];
  assign c3       = c_vec[C_HIT];
  assign c4       = c_vec[C_MREQ];
  assign c5       = c_vec[C_VICT];
  assign c6       = c_vec[C_FILL];
  assign c7       = c_vec[C_VLRU];
  assign addr_out = addr_q;
  assign resp_hit = resp_valid & hit_q;
  assign resp_err = resp_valid & err_q;

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl_stats #(.CNT_W(CNT_W)) u_stats (
    .clk           (clk),
    .rst           (rst),
    .evt_valid     (resp_valid),
    .evt_hit       (hit_q),
    .evt_err       (err_q),
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_timeouts (stat_timeouts)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb/tb_cache_ctrl_fsm.sv - scoreboard bench: directed requests, monitor compares strobe trace, flags and latency
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] addr_out;
  logic        c0, c1, c2, c3, c4, c5, c6, c7;
  logic        hit_or_miss, space_in_lru, mem_valid;
  logic        resp_valid, resp_hit, resp_err;
`ifdef CACHE_CTRL_STATS_EN
  logic [1:0]  stat_hits, stat_misses, stat_timeouts;
`endif

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl_fsm #(.CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .addr_out      (addr_out),
    .c0            (c0),
    .c1            (c1),
    .c2            (c2),
    .c3            (c3),
    .c4            (c4),
    .c5            (c5),
    .c6            (c6),
    .c7            (c7),
    .hit_or_miss   (hit_or_miss),
    .space_in_lru  (space_in_lru),
    .mem_valid     (mem_valid),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_err      (resp_err),
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses),
    .stat_timeouts (stat_timeouts)
  );
`else
  cache_ctrl_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .addr_out     (addr_out),
    .c0           (c0),
    .c1           (c1),
    .c2           (c2),
    .c3           (c3),
    .c4           (c4),
    .c5           (c5),
    .c6           (c6),
    .c7           (c7),
    .hit_or_miss  (hit_or_miss),
    .space_in_lru (space_in_lru),
    .mem_valid    (mem_valid),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_err     (resp_err)
  );
`endif

  always #5 clk = ~clk;

  wire [7:0] strobes = {c7, c6, c5, c4, c3, c2, c1, c0};

  typedef struct {
    logic        hit;
    logic        err;
    int          lat;
    int          n;
    logic [63:0] trace;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   c7_total = 0;

  logic m_hit1 = 1'b0, m_hit2 = 1'b0, m_space = 1'b0;
  int   m_delay = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // cache/memory model: hit flag flips to the second-pass value once the line is filled
  initial begin
    int  mcnt;
    logic filled;
    mcnt = -1;
    filled = 1'b0;
    mem_valid = 1'b0;
    hit_or_miss = 1'b0;
    space_in_lru = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        filled = 1'b0;
        mcnt = -1;
        mem_valid = 1'b0;
      end else begin
        if (c6) filled = 1'b1;
        if (resp_valid) begin
          filled = 1'b0;
          mcnt = -1;
        end
        if (c4) mcnt = 0;
        else if (mcnt >= 0) mcnt++;
        mem_valid = (mcnt >= 0) && (mcnt == m_delay);
        if (mem_valid) mcnt = -1;
      end
      hit_or_miss = filled ? m_hit2 : m_hit1;
      space_in_lru = m_space;
    end
  end

  initial begin
    logic [63:0] tr;
    int          trn;
    exp_t        e;
    tr = '0;
    trn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tr = '0;
        trn = 0;
      end else begin
        if (strobes != 8'h00) begin
          if (trn < 8) tr[trn*8 +: 8] = strobes;
          trn++;
          if (c7) c7_total++;
          if (c3) chk("c3_exclusive", {56'h0, strobes & 8'he0}, 64'h0);
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            chk("resp_hit", resp_hit, e.hit);
            chk("resp_err", resp_err, e.err);
            chk("latency", cyc - e.acc, e.lat);
            chk("strobe_count", trn, e.n);
            chk("strobe_trace", tr, e.trace);
          end
          tr = '0;
          trn = 0;
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic h1, input logic h2,
                       input logic sp, input int md, input bit push, input logic eh, input logic ee,
                       input int lat, input int n, input logic [63:0] trace, output int acc);
    int   k;
    exp_t e;
    @(negedge clk);
    m_hit1 = h1;
    m_hit2 = h2;
    m_space = sp;
    m_delay = md;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    k = 0;
    while (!req_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    acc = cyc;
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
      req_valid = 1'b0;
    end else begin
      if (push) begin
        e.hit = eh;
        e.err = ee;
        e.lat = lat;
        e.n = n;
        e.trace = trace;
        e.acc = cyc;
        exp_q.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("addr_out", addr_out, addr);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a1, a2, k;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_strobes", strobes, 8'h00);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_addr_out", addr_out, 32'h0);

    // read miss, fill, second pass hit
    issue(1'b0, 32'h0000_2040, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 19, 7, 64'h000A_0240_2010_0201, a1);
    wait_drain();
    // repeat read hits
    issue(1'b0, 32'h0000_2040, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 7, 3, 64'h0A_0201, a1);
    wait_drain();
    // write hit and write miss
    issue(1'b1, 32'h0000_3080, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 7, 3, 64'h08_0401, a1);
    wait_drain();
    issue(1'b1, 32'h0000_40C0, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 19, 7, 64'h0008_0440_2010_0401, a1);
    wait_drain();

    // back-to-back hits: no accept in DONE, spacing LOOKUP_LAT+5
    issue(1'b0, 32'h0000_1000, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 7, 3, 64'h0A_0201, a1);
    issue(1'b0, 32'h0000_1004, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 7, 3, 64'h0A_0201, a2);
    chk("accept_spacing", a2 - a1, 8);
    wait_drain();

    // five misses to one index, LRU eviction only on the fifth
    for (int n = 0; n < 5; n++) begin
      if (n < 4)
        issue(1'b0, 32'h0000_0040 + n * 32'h2000, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 19, 7,
              64'h000A_0240_2010_0201, a1);
      else
        issue(1'b0, 32'h0000_0040 + n * 32'h2000, 1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0, 20, 8,
              64'h0A02_4080_2010_0201, a1);
      wait_drain();
    end
    chk("c7_pulses", c7_total, 1);

    // memory never answers
    issue(1'b0, 32'h0000_5000, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b1, 262, 3, 64'h10_0201, a1);
    wait_drain();
    // fill does not cure the miss
    issue(1'b1, 32'h0000_6000, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, 16, 6, 64'h0440_2010_0401, a1);
    wait_drain();

    // reset during MEM_WAIT: abort, no response
    issue(1'b0, 32'h0000_7000, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 64'h0, a1);
    k = 0;
    while (!c4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("c4_seen", c4, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_strobes", strobes, 8'h00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

`ifdef CACHE_CTRL_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      issue(1'b0, 32'h0000_8000 + n * 32'h4, 1'b1, 1'b1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 7, 3, 64'h0A_0201, a1);
      wait_drain();
    end
    chk("stat_hits_sat", stat_hits, 2'd3);
    chk("stat_misses", stat_misses, 2'd0);
    chk("stat_timeouts", stat_timeouts, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
